// File: rtl/ct_piu_l2pmp_pkg.sv
// Shared definitions for the L2 PMP APB register block.
// Covers the map offsets, cfg field positions, A-mode encodings and FSM states.
package ct_piu_l2pmp_pkg;

  localparam logic [11:0] CFG_BASE  = 12'h000;
  localparam logic [11:0] ADDR_BASE = 12'h100;

  localparam int CFG_L_BIT   = 7;
  localparam int CFG_A_MSB   = 4;
  localparam int CFG_A_LSB   = 3;
  localparam int CFG_XWR_MSB = 2;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } pmp_amode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Keep only L, A and XWR; reserved bits [6:5] always store as zero.
  function automatic logic [7:0] cfg_wr_filter(input logic [31:0] wdata);
    return {wdata[CFG_L_BIT], 2'b00, wdata[CFG_A_MSB:CFG_A_LSB], wdata[CFG_XWR_MSB:0]};
  endfunction

endpackage

// File: rtl/ct_piu_l2pmp_entry.sv
// One L2 PMP entry: cfg and address registers with lock gating.
// A set L bit blocks every later write until reset.
module ct_piu_l2pmp_entry
  import ct_piu_l2pmp_pkg::*;
#(
  parameter int ADDR_W = 28
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              cfg_we,
  input  logic              addr_we,
  input  logic [31:0]       wdata,
  output logic [7:0]        cfg,
  output logic [ADDR_W-1:0] addr,
  output logic              commit
);

  logic [7:0]        cfg_q;
  logic [7:0]        cfg_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              locked_s;
  logic              unused_wdata_s;

  assign locked_s       = cfg_q[CFG_L_BIT];
  assign unused_wdata_s = ^wdata;

  // Next-state for the entry registers; a locked entry ignores writes.
  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    commit = 1'b0;
    if (!locked_s && cfg_we) begin
      cfg_d  = cfg_wr_filter(wdata);
      commit = 1'b1;
    end else if (!locked_s && addr_we) begin
      addr_d = wdata[ADDR_W-1:0];
      commit = 1'b1;
    end else begin
      cfg_d  = cfg_q;
      addr_d = addr_q;
    end
  end

  // Entry storage; cleared only by reset.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cfg_q  <= 8'h00;
      addr_q <= {ADDR_W{1'b0}};
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end

  assign cfg  = cfg_q;
  assign addr = addr_q;

endmodule

// File: rtl/ct_piu_l2pmp_apb.sv
// APB slave holding ENTRY_NUM L2 PMP entries (cfg array at 0x000, addr array at 0x100).
// Writes commit at the end of the pready cycle; update pulses one cycle later.
module ct_piu_l2pmp_apb
  import ct_piu_l2pmp_pkg::*;
#(
  parameter int ENTRY_NUM = 8,
  parameter int ADDR_W    = 28,
  parameter int WAIT_CYC  = 1
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst_b,
  input  logic                        psel_l2pmp_x,
  input  logic                        penable_x,
  input  logic                        x_pwrite,
  input  logic [11:0]                 x_paddr,
  input  logic [31:0]                 x_pwdata,
  output logic                        pready_l2pmp_x,
  output logic                        perr_l2pmp_x,
  output logic [31:0]                 x_prdata_l2pmp,
  output logic [8*ENTRY_NUM-1:0]      l2pmp_xx_cfg,
  output logic [ADDR_W*ENTRY_NUM-1:0] l2pmp_xx_addr,
  output logic                        l2pmp_xx_update
);

  apb_state_e        state_q;
  apb_state_e        state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              update_q;
  logic              update_d;

  logic [3:0]        idx_s;
  logic              cfg_hit_s;
  logic              addr_hit_s;
  logic              mapped_s;
  logic              pready_s;
  logic              wr_ok_s;
  logic [7:0]        rd_cfg_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ENTRY_NUM-1:0] commit_s;
  logic [7:0]        cfg_arr_s  [ENTRY_NUM];
  logic [ADDR_W-1:0] addr_arr_s [ENTRY_NUM];

  // Both arrays reserve 16 word slots; slots at or beyond ENTRY_NUM are unmapped.
  assign idx_s      = x_paddr[5:2];
  assign cfg_hit_s  = (x_paddr[11:6] == CFG_BASE[11:6]);
  assign addr_hit_s = (x_paddr[11:6] == ADDR_BASE[11:6]);
  assign mapped_s   = (cfg_hit_s || addr_hit_s) &&
                      ({1'b0, idx_s} < 5'(ENTRY_NUM)) &&
                      (x_paddr[1:0] == 2'b00);

  assign pready_s = (state_q == ST_ACCESS) && psel_l2pmp_x && penable_x &&
                    (cnt_q == 2'(WAIT_CYC));
  assign wr_ok_s  = pready_s && x_pwrite && mapped_s;

  assign pready_l2pmp_x = pready_s;
  assign perr_l2pmp_x   = pready_s && !mapped_s;

  // APB transfer FSM and wait counter next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (psel_l2pmp_x && !penable_x) begin
          state_d = ST_ACCESS;
          cnt_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 2'd1;
        if (pready_s || !psel_l2pmp_x) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  assign update_d = |commit_s;

  // FSM, counter and update-pulse registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      update_q <= update_d;
    end
  end

  assign l2pmp_xx_update = update_q;

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_entry
    ct_piu_l2pmp_entry #(
      .ADDR_W (ADDR_W)
    ) u_entry (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .cfg_we         (wr_ok_s && cfg_hit_s && (idx_s == 4'(g))),
      .addr_we        (wr_ok_s && addr_hit_s && (idx_s == 4'(g))),
      .wdata          (x_pwdata),
      .cfg            (cfg_arr_s[g]),
      .addr           (addr_arr_s[g]),
      .commit         (commit_s[g])
    );
    assign l2pmp_xx_cfg[8*g +: 8]            = cfg_arr_s[g];
    assign l2pmp_xx_addr[ADDR_W*g +: ADDR_W] = addr_arr_s[g];
  end

  // Select the addressed entry for read-back.
  always_comb begin
    rd_cfg_s  = 8'h00;
    rd_addr_s = {ADDR_W{1'b0}};
    for (int i = 0; i < ENTRY_NUM; i++) begin
      rd_cfg_s  = rd_cfg_s  | ((idx_s == 4'(i)) ? cfg_arr_s[i]  : 8'h00);
      rd_addr_s = rd_addr_s | ((idx_s == 4'(i)) ? addr_arr_s[i] : {ADDR_W{1'b0}});
    end
  end

  // Read data is driven only for a successful read in its pready cycle.
  always_comb begin
    x_prdata_l2pmp = 32'h0000_0000;
    if (pready_s && !x_pwrite && mapped_s) begin
      if (cfg_hit_s) begin
        x_prdata_l2pmp = {24'h00_0000, rd_cfg_s};
      end else begin
        x_prdata_l2pmp = 32'(rd_addr_s);
      end
    end else begin
      x_prdata_l2pmp = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_ct_piu_l2pmp_apb.sv
// Randomized self-checking bench for ct_piu_l2pmp_apb against a register-map model.
// Extra instances with WAIT_CYC=0 and 3 share the bus and are used for latency checks only.
module tb_ct_piu_l2pmp_apb;

  localparam int NE  = 8;
  localparam int AW  = 28;
  localparam int WC  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [11:0]   paddr = 12'h000;
  logic [31:0]   pwdata = 32'h0;

  logic          pready, perr, upd;
  logic [31:0]   prdata;
  logic [8*NE-1:0]  cfg_out;
  logic [AW*NE-1:0] addr_out;

  logic          w0_pready, w3_pready;
  logic          unused_w0_perr, unused_w3_perr, unused_w0_upd, unused_w3_upd;
  logic [31:0]   unused_w0_rd, unused_w3_rd;
  logic [8*NE-1:0]  unused_w0_cfg, unused_w3_cfg;
  logic [AW*NE-1:0] unused_w0_addr, unused_w3_addr;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]    m_cfg  [NE];
  logic [AW-1:0] m_addr [NE];

  always #5 clk = ~clk;

  ct_piu_l2pmp_apb #(.ENTRY_NUM(NE), .ADDR_W(AW), .WAIT_CYC(WC)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .psel_l2pmp_x(psel), .penable_x(penable),
    .x_pwrite(pwrite), .x_paddr(paddr), .x_pwdata(pwdata), .pready_l2pmp_x(pready),
    .perr_l2pmp_x(perr), .x_prdata_l2pmp(prdata), .l2pmp_xx_cfg(cfg_out),
    .l2pmp_xx_addr(addr_out), .l2pmp_xx_update(upd));

  ct_piu_l2pmp_apb #(.ENTRY_NUM(NE), .ADDR_W(AW), .WAIT_CYC(0)) dut_w0 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .psel_l2pmp_x(psel), .penable_x(penable),
    .x_pwrite(pwrite), .x_paddr(paddr), .x_pwdata(pwdata), .pready_l2pmp_x(w0_pready),
    .perr_l2pmp_x(unused_w0_perr), .x_prdata_l2pmp(unused_w0_rd), .l2pmp_xx_cfg(unused_w0_cfg),
    .l2pmp_xx_addr(unused_w0_addr), .l2pmp_xx_update(unused_w0_upd));

  ct_piu_l2pmp_apb #(.ENTRY_NUM(NE), .ADDR_W(AW), .WAIT_CYC(3)) dut_w3 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .psel_l2pmp_x(psel), .penable_x(penable),
    .x_pwrite(pwrite), .x_paddr(paddr), .x_pwdata(pwdata), .pready_l2pmp_x(w3_pready),
    .perr_l2pmp_x(unused_w3_perr), .x_prdata_l2pmp(unused_w3_rd), .l2pmp_xx_cfg(unused_w3_cfg),
    .l2pmp_xx_addr(unused_w3_addr), .l2pmp_xx_update(unused_w3_upd));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Map decode from the register map: 0 = unmapped, 1 = cfg, 2 = addr.
  function automatic int ref_kind(input logic [11:0] a, output int idx);
    int off;
    off = int'(a);
    idx = 0;
    if (off % 4 != 0) return 0;
    if (off < 4 * NE) begin
      idx = off / 4;
      return 1;
    end
    if (off >= 256 && off < 256 + 4 * NE) begin
      idx = (off - 256) / 4;
      return 2;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = '0;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NE; i++) begin
      check_eq($sformatf("%s_cfg%0d", tag, i), cfg_out[8*i +: 8], m_cfg[i]);
      check_eq($sformatf("%s_addr%0d", tag, i), addr_out[AW*i +: AW], m_addr[i]);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d);
    int kind, idx, n;
    logic [31:0] exp_rd, got_rd;
    logic exp_commit, got_rdy, got_err;
    kind = ref_kind(a, idx);
    exp_rd = 32'h0;
    exp_commit = 1'b0;
    got_rdy = 1'b0;
    got_err = 1'b0;
    got_rd = 32'h0;
    if (!wr && kind == 1) exp_rd = {24'h0, m_cfg[idx]};
    if (!wr && kind == 2) exp_rd = 32'(m_addr[idx]);
    if (wr && kind != 0 && !m_cfg[idx][7]) exp_commit = 1'b1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!got_rdy && n < 8) begin
      @(negedge clk);
      n++;
      if (pready) begin
        got_rdy = 1'b1;
        got_err = perr;
        got_rd  = prdata;
      end else begin
        @(posedge clk);
      end
    end
    check_eq($sformatf("latency@%03h", a), n, WC + 1);
    check_eq($sformatf("perr@%03h", a), got_err, (kind == 0));
    check_eq($sformatf("prdata@%03h", a), got_rd, exp_rd);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    if (exp_commit && kind == 1) m_cfg[idx] = d[7:0] & 8'h9F;
    if (exp_commit && kind == 2) m_addr[idx] = d[AW-1:0];
    @(negedge clk);
    check_eq($sformatf("update@%03h", a), upd, exp_commit);
    check_regs("regs");
    @(negedge clk);
    check_eq("update_one_cycle", upd, 1'b0);
  endtask

  task automatic latency_test();
    logic [4:0] m0, m2, m3;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m0[k] = w0_pready;
      m2[k] = pready;
      m3[k] = w3_pready;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    check_eq("lat_wait0", m0, 5'b00001);
    check_eq("lat_wait2", m2, 5'b00100);
    check_eq("lat_wait3", m3, 5'b01000);
  endtask

  task automatic abort_test(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq("abort_no_pready", pready, 1'b0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("abort_no_update", upd, 1'b0);
    end
    check_regs("abort");
  endtask

  task automatic reset_mid_transfer();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h1F;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_pready", pready, 1'b0);
    check_eq("rst_perr", perr, 1'b0);
    check_eq("rst_prdata", prdata, 32'h0);
    check_eq("rst_update", upd, 1'b0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("post_rst_pready", pready, 1'b0);
    check_regs("post_rst");
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_pready", pready, 1'b0);
    check_eq("reset_perr", perr, 1'b0);
    check_eq("reset_prdata", prdata, 32'h0);
    check_eq("reset_update", upd, 1'b0);
    check_regs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    apb_xfer(1'b1, 12'h004, 32'h0000_0019);
    apb_xfer(1'b0, 12'h004, 32'h0);
    check_eq("cfg1_byte", cfg_out[15:8], 8'h19);

    latency_test();

    abort_test(12'h100, 32'h0ABC_DEF1);
    apb_xfer(1'b0, 12'h100, 32'h0);

    apb_xfer(1'b1, 12'h008, 32'h0000_0080);
    apb_xfer(1'b1, 12'h008, 32'h0000_000F);
    apb_xfer(1'b1, 12'h108, 32'h0000_1234);
    check_eq("locked_cfg2", cfg_out[23:16], 8'h80);
    check_eq("locked_addr2", addr_out[2*AW +: AW], 28'h0);

    apb_xfer(1'b0, 12'h020, 32'h0);
    apb_xfer(1'b1, 12'h102, 32'hFFFF_FFFF);
    apb_xfer(1'b1, 12'h00C, 32'hFFFF_FF7F);
    apb_xfer(1'b1, 12'h11C, 32'hFFFF_FFFF);
    apb_xfer(1'b0, 12'h11C, 32'h0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: a = 12'(4 * $urandom_range(0, NE - 1));
        1: a = 12'h100 + 12'(4 * $urandom_range(0, NE - 1));
        2: a = ($urandom_range(0, 1) ? 12'h100 : 12'h000) + 12'(4 * $urandom_range(NE, 15));
        3: a = 12'(4 * $urandom_range(0, NE - 1) + $urandom_range(1, 3)) + ($urandom_range(0, 1) ? 12'h100 : 12'h000);
        default: a = ($urandom_range(0, 1) ? 12'h040 : 12'h200) + 12'(4 * $urandom_range(0, 15));
      endcase
      d = $urandom;
      if ($urandom_range(0, 7) != 0) d[7] = 1'b0;
      apb_xfer(1'($urandom_range(0, 1)), a, d);
    end

    reset_mid_transfer();
    apb_xfer(1'b1, 12'h008, 32'h0000_001F);
    check_eq("unlock_after_rst", cfg_out[23:16], 8'h1F);
    apb_xfer(1'b1, 12'h108, 32'h0765_4321);
    apb_xfer(1'b0, 12'h108, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
